// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: sequencer and architectural HI/LO holder for a fixed-latency
// iterative divider.
//
// A DIV request latches rs/rt into op_a/op_b, which drive div_a/div_b for the
// whole operation. The block pulses div_start, counts DIV_LATENCY edges, and
// then captures div_hi/div_lo into hi_out/lo_out with a one-cycle done.
// A divisor of zero never starts the divider. It raises div_zero_exc for one
// cycle and leaves HI/LO unchanged. MTHI/MTLO write HI/LO directly while idle.
//
// Optional build macro HILO_REM_SIGN_FIX_EN: HI is sign-corrected at capture
// so that the remainder takes the sign of the dividend. Without the macro, HI
// is the divider remainder unmodified, and its sign follows the divisor.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   div_req, mthi_we, mtlo_we  control-unit requests, sampled only in IDLE
//   rs_data, rt_data           dividend / MT source, divisor
//   div_start, div_a, div_b    divider start pulse and held operands
//   div_hi, div_lo             divider remainder / quotient
//   busy                       state != IDLE (combinational)
//   done, div_zero_exc         one-cycle completion / divide-by-zero pulses
//   hi_out, lo_out             architectural HI / LO
module hilo_div_ctrl #(
    parameter int DIV_LATENCY = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        div_req,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        div_start,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero_exc,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam int CW = (DIV_LATENCY > 2) ? $clog2(DIV_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(DIV_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        ZERO    = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [31:0]   op_a, op_b;
    logic [31:0]   hi_cap;

    // The divider samples B on every iteration, so the operands are fed
    // straight from the latched copies.
    assign div_a = op_a;
    assign div_b = op_b;
    assign busy  = (state != IDLE);

`ifdef HILO_REM_SIGN_FIX_EN
    // The divider gives the remainder the divisor's sign. First recover the
    // magnitude, then apply the dividend's sign.
    logic [31:0] rem_mag;
    always_comb begin
        rem_mag = op_b[31] ? (32'd0 - div_hi) : div_hi;
        hi_cap  = op_a[31] ? (32'd0 - rem_mag) : rem_mag;
    end
`else
    assign hi_cap = div_hi;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (div_req) state_n = (rt_data == 32'd0) ? ZERO : START;
            START:   state_n = WAIT;
            // The count reaches 1 on edge E(DIV_LATENCY), when the divider
            // writes its final result.
            WAIT:    if (cnt == CW'(1)) state_n = CAPTURE;
            CAPTURE: state_n = IDLE;
            ZERO:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            op_a         <= '0;
            op_b         <= '0;
            hi_out       <= '0;
            lo_out       <= '0;
            div_start    <= 1'b0;
            done         <= 1'b0;
            div_zero_exc <= 1'b0;
        end else begin
            state        <= state_n;
            // Registered pulses are timed so that each one lines up with the
            // state it belongs to.
            div_start    <= (state_n == START);
            done         <= (state == CAPTURE);
            div_zero_exc <= (state == ZERO);
            case (state)
                IDLE: begin
                    if (div_req) begin
                        // A DIV takes priority. A simultaneous MTHI or MTLO
                        // is dropped.
                        op_a <= rs_data;
                        op_b <= rt_data;
                    end else begin
                        if (mthi_we) hi_out <= rs_data;
                        if (mtlo_we) lo_out <= rs_data;
                    end
                end
                START:   cnt <= CNT_INIT;
                WAIT:    cnt <= cnt - CW'(1);
                CAPTURE: begin
                    hi_out <= hi_cap;
                    lo_out <= div_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
module tb_hilo_div_ctrl;

    localparam int L = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        div_req = 1'b0, mthi_we = 1'b0, mtlo_we = 1'b0;
    logic [31:0] rs_data = '0, rt_data = '0;
    logic        div_start, busy, done, div_zero_exc;
    logic [31:0] div_a, div_b, div_hi, div_lo, hi_out, lo_out;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt  = 0;
    int start_cnt = 0;
    int zexc_cnt  = 0;

    hilo_div_ctrl #(.DIV_LATENCY(L)) dut (
        .clk(clk), .reset(reset),
        .div_req(div_req), .mthi_we(mthi_we), .mtlo_we(mtlo_we),
        .rs_data(rs_data), .rt_data(rt_data),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_hi(div_hi), .div_lo(div_lo),
        .busy(busy), .done(done), .div_zero_exc(div_zero_exc),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    // Divider stub. The quotient has the sign of a^b. The remainder has the
    // divisor's sign. The final result appears on edge E(L), and a garbage
    // value is shown before that.
    function automatic logic [63:0] ref_div(logic [31:0] a, logic [31:0] b);
        logic [31:0] ma, mb, q, r;
        ma = a[31] ? -a : a;
        mb = b[31] ? -b : b;
        if (mb == 0) return 64'd0;
        q = ma / mb;
        r = ma % mb;
        if (a[31] ^ b[31]) q = -q;
        if (b[31]) r = -r;
        return {r, q};
    endfunction

    int scnt = 0;
    always @(posedge clk) begin
        if (reset) begin
            scnt <= 0; div_hi <= '0; div_lo <= '0;
        end else if (div_start) begin
            scnt <= L - 1; div_hi <= 32'hBAD0BAD0; div_lo <= 32'hBAD1BAD1;
        end else if (scnt != 0) begin
            scnt <= scnt - 1;
            if (scnt == 1) {div_hi, div_lo} <= ref_div(div_a, div_b);
        end
    end

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (div_start) start_cnt <= start_cnt + 1;
        if (div_zero_exc) zexc_cnt <= zexc_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to cycle k+1: one edge, then 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a DIV and follow it to completion. inj adds a second request
    // (plus MTHI) in cycle 5, while the unit is busy.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo,
                           input bit with_mthi, input bit inj);
        int extra_start, not_busy, early_done;
        int d0;
        logic [31:0] hi0;
        extra_start = 0; not_busy = 0; early_done = 0;
        d0  = done_cnt;
        hi0 = hi_out;
        rs_data = a; rt_data = b; div_req = 1'b1; mthi_we = with_mthi;
        tick();                                   // cycle 0
        div_req = 1'b0; mthi_we = 1'b0;
        chk({tag, "_start0"}, {31'd0, div_start}, 32'd1);
        chk({tag, "_busy0"}, {31'd0, busy}, 32'd1);
        chk({tag, "_hi_hold0"}, hi_out, hi0);
        for (int k = 1; k <= L; k++) begin
            if (inj && k == 5) begin
                div_req = 1'b1; mthi_we = 1'b1; rs_data = 32'd50; rt_data = 32'd3;
            end
            tick();                               // cycle k
            if (inj && k == 5) begin
                div_req = 1'b0; mthi_we = 1'b0;
                chk({tag, "_div_a_held"}, div_a, a);
                chk({tag, "_div_b_held"}, div_b, b);
            end
            if (div_start) extra_start++;
            if (!busy) not_busy++;
            if (done) early_done++;
        end
        chk({tag, "_extra_start"}, extra_start, 0);
        chk({tag, "_not_busy"}, not_busy, 0);
        chk({tag, "_early_done"}, early_done, 0);
        tick();                                   // cycle L+1
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hi"}, hi_out, ehi);
        chk({tag, "_lo"}, lo_out, elo);
        tick();
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        tick(); tick();
        chk({tag, "_done_count"}, done_cnt - d0, 1);
    endtask

    initial begin
        int d0, s0;
        // Reset state.
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        chk("rst_start", {31'd0, div_start}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_div_a", div_a, 32'd0);
        tick();

        // Basic positive divide.
        run_div("d100_7", 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);

        // Signed cases where the macro changes HI.
`ifdef HILO_REM_SIGN_FIX_EN
        run_div("dm7_2", 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        run_div("d7_m2", 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0);
`else
        run_div("dm7_2", 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0);
        run_div("d7_m2", 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
`endif

        // Divide by zero after preloading HI.
        rs_data = 32'h11111111; mthi_we = 1'b1;
        tick();
        mthi_we = 1'b0;
        chk("z_preload_hi", hi_out, 32'h11111111);
        d0 = done_cnt; s0 = start_cnt;
        rs_data = 32'd5; rt_data = 32'd0; div_req = 1'b1;
        tick();                                   // cycle 0
        div_req = 1'b0;
        chk("z_busy0", {31'd0, busy}, 32'd1);
        chk("z_start0", {31'd0, div_start}, 32'd0);
        chk("z_exc0", {31'd0, div_zero_exc}, 32'd0);
        tick();                                   // cycle 1
        chk("z_exc1", {31'd0, div_zero_exc}, 32'd1);
        chk("z_busy1", {31'd0, busy}, 32'd0);
        chk("z_done1", {31'd0, done}, 32'd0);
        tick();
        chk("z_exc_pulse", {31'd0, div_zero_exc}, 32'd0);
        tick(); tick();
        chk("z_hi", hi_out, 32'h11111111);
        chk("z_no_start", start_cnt - s0, 0);
        chk("z_no_done", done_cnt - d0, 0);
        chk("z_exc_count", zexc_cnt, 1);

        // MTHI / MTLO.
        rs_data = 32'hDEADBEEF; mthi_we = 1'b1;
        tick();
        mthi_we = 1'b0;
        chk("mthi", hi_out, 32'hDEADBEEF);
        rs_data = 32'hCAFEF00D; mtlo_we = 1'b1;
        tick();
        mtlo_we = 1'b0;
        chk("mtlo", lo_out, 32'hCAFEF00D);
        chk("mtlo_hi_kept", hi_out, 32'hDEADBEEF);
        rs_data = 32'h0000AAAA; mthi_we = 1'b1; mtlo_we = 1'b1;
        tick();
        mthi_we = 1'b0; mtlo_we = 1'b0;
        chk("mthilo_hi", hi_out, 32'h0000AAAA);
        chk("mthilo_lo", lo_out, 32'h0000AAAA);

        // MTHI at the same time as div_req is dropped.
        run_div("mthi_req", 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, 1'b0);

        // A request while busy is ignored, and there is exactly one done.
        run_div("busy_req", 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);

        // Reset in the middle of an operation.
        d0 = done_cnt;
        rs_data = 32'd100; rt_data = 32'd7; div_req = 1'b1;
        tick();                                   // cycle 0
        div_req = 1'b0;
        for (int k = 1; k <= 10; k++) tick();     // cycle 10
        reset = 1'b1;
        tick();                                   // cycle 11
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_hi", hi_out, 32'd0);
        chk("mid_rst_lo", lo_out, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 40; k++) tick();
        chk("mid_rst_no_done", done_cnt - d0, 0);
        chk("mid_rst_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Overall time bound on the run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
